// File: rtl/data_memory_pkg.sv
// ----------------------------------------------------------------------------
// data_memory_pkg
// Shared types and helpers for the byte-addressable data memory of the
// multicycle RISC-V datapath.
//  - mem_size_e   : decoded access size (byte / halfword / word / none)
//  - MEM_WIDTH    : data width in bits (one word = 4 bytes)
//  - MEM_DEPTH    : byte-address width in bits
//  - MEM_BYTES    : capacity in bytes
//  - decodeSize() : priority decode of the three size flags
//  - sizeBytes()  : number of bytes touched by an access of a given size
// ----------------------------------------------------------------------------
package data_memory_pkg;

   localparam int MEM_WIDTH = 32;
   localparam int MEM_DEPTH = 12;
   localparam int MEM_BYTES = 2 ** MEM_DEPTH;

   typedef enum logic [1:0] {
      SZ_BYTE,
      SZ_HALF,
      SZ_WORD,
      SZ_NONE
   } mem_size_e;

   // The flags are not one-hot from the control unit, so the smallest size
   // that is requested wins; no flag at all means no access.
   function automatic mem_size_e decodeSize(input logic oneByte,
                                            input logic twoByte,
                                            input logic fourBytes);
      mem_size_e size;
      if (oneByte)
         size = SZ_BYTE;
      else if (twoByte)
         size = SZ_HALF;
      else if (fourBytes)
         size = SZ_WORD;
      else
         size = SZ_NONE;
      return size;
   endfunction

   function automatic logic [2:0] sizeBytes(input mem_size_e size);
      logic [2:0] n;
      case (size)
         SZ_BYTE: n = 3'd1;
         SZ_HALF: n = 3'd2;
         SZ_WORD: n = 3'd4;
         default: n = 3'd0;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/data_memory_load_extend.sv
// ----------------------------------------------------------------------------
// data_memory_load_extend
// Turns the four raw bytes fetched at the load address into the 32-bit load
// result: byte and halfword loads are sign- or zero-extended, word loads pass
// straight through.
// Ports:
//  i_raw          in   32   bytes mem[A+3..A] (little-endian, out-of-range = 0)
//  i_size         in   2    decoded access size (mem_size_e)
//  i_unsignedLoad in   1    1 = zero-extend, 0 = sign-extend
//  o_data         out  32   extended load value (0 when size is SZ_NONE)
// ----------------------------------------------------------------------------
module data_memory_load_extend
   import data_memory_pkg::*;
(
   input  logic [MEM_WIDTH-1:0] i_raw,
   input  mem_size_e            i_size,
   input  logic                 i_unsignedLoad,
   output logic [MEM_WIDTH-1:0] o_data
);

   logic w_signByte;
   logic w_signHalf;

   // Sign bit that gets replicated into the upper bits; forced to 0 for
   // unsigned loads so the same concatenation serves both cases.
   always_comb begin
      w_signByte = ~i_unsignedLoad & i_raw[7];
      w_signHalf = ~i_unsignedLoad & i_raw[15];
   end

   // Size-dependent extension; word loads ignore the unsigned flag.
   always_comb begin
      o_data = '0;
      case (i_size)
         SZ_BYTE: o_data = {{24{w_signByte}}, i_raw[7:0]};
         SZ_HALF: o_data = {{16{w_signHalf}}, i_raw[15:0]};
         SZ_WORD: o_data = i_raw;
         default: o_data = '0;
      endcase
   end

endmodule

// File: rtl/data_memory.sv
// ----------------------------------------------------------------------------
// data_memory
// Byte-addressable, little-endian data memory for the load/store stage.
// Stores are synchronous, loads are combinational; accesses of 1, 2 or 4 bytes
// may start at any byte address. Bytes that would fall past the top of memory
// are dropped on stores and read as 0x00 on loads (no wrap-around).
// Ports:
//  clk            in   1       system clock, rising edge
//  rst            in   1       asynchronous active-low reset (clears memory)
//  MemWrite       in   1       store enable, sampled on posedge clk
//  MemRead        in   1       load enable (combinational)
//  one_byte       in   1       access size: byte   (highest priority)
//  two_byte       in   1       access size: halfword
//  four_bytes     in   1       access size: word    (lowest priority)
//  unsigned_load  in   1       zero-extend byte/halfword loads when 1
//  Address        in   DEPTH   byte address of the least-significant byte
//  WriteData      in   WIDTH   store data, low 8/16/32 bits used
//  ReadData       out  WIDTH   load result, 0 when idle or in reset
// ----------------------------------------------------------------------------
module data_memory
   import data_memory_pkg::*;
#(
   parameter int WIDTH = MEM_WIDTH,
   parameter int DEPTH = MEM_DEPTH
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             MemWrite,
   input  logic             MemRead,
   input  logic             one_byte,
   input  logic             two_byte,
   input  logic             four_bytes,
   input  logic             unsigned_load,
   input  logic [DEPTH-1:0] Address,
   input  logic [WIDTH-1:0] WriteData,
   output logic [WIDTH-1:0] ReadData
);

   localparam int BYTES      = 2 ** DEPTH;
   localparam int LANES      = WIDTH / 8;

   logic [7:0]       r_mem [BYTES];

   mem_size_e        w_size;
   logic [2:0]       w_nBytes;
   logic [DEPTH:0]   w_byteAddr [LANES];
   logic [LANES-1:0] w_inRange;
   logic [WIDTH-1:0] w_raw;
   logic [WIDTH-1:0] w_extended;

   // Decode the size flags once; both the store and the load path use it.
   always_comb begin
      w_size   = decodeSize(one_byte, two_byte, four_bytes);
      w_nBytes = sizeBytes(w_size);
   end

   // Per-lane byte addresses carry one extra bit so that an access running
   // off the top of memory is detected instead of silently wrapping to 0.
   always_comb begin
      for (int k = 0; k < LANES; k++) begin
         w_byteAddr[k] = {1'b0, Address} + (DEPTH + 1)'(k);
         w_inRange[k]  = ~w_byteAddr[k][DEPTH];
      end
   end

   // Gather the four bytes starting at Address; lanes past the top of memory
   // read as zero so a partial halfword/word at the boundary is well defined.
   always_comb begin
      w_raw = '0;
      for (int k = 0; k < LANES; k++) begin
         if (w_inRange[k])
            w_raw[8*k +: 8] = r_mem[w_byteAddr[k][DEPTH-1:0]];
      end
   end

   // Byte array: cleared as a whole on reset, otherwise each enabled lane
   // that is inside the address space takes its slice of WriteData.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < BYTES; i++)
            r_mem[i] <= 8'h00;
      end else if (MemWrite) begin
         for (int k = 0; k < LANES; k++) begin
            if ((3'(k) < w_nBytes) && w_inRange[k])
               r_mem[w_byteAddr[k][DEPTH-1:0]] <= WriteData[8*k +: 8];
         end
      end
   end

   data_memory_load_extend u_loadExtend (
      .i_raw          (w_raw),
      .i_size         (w_size),
      .i_unsignedLoad (unsigned_load),
      .o_data         (w_extended)
   );

   // The output is gated rather than registered: loads are zero-latency, and
   // an idle or reset memory must present a clean zero to the datapath.
   always_comb begin
      ReadData = '0;
      if (rst && MemRead)
         ReadData = w_extended;
   end

endmodule

// File: tb/tb_data_memory.sv
// ----------------------------------------------------------------------------
// tb_data_memory
// Directed self-checking bench for data_memory. Each load pushes its expected
// value onto a scoreboard queue; the value is popped and compared against
// ReadData once the combinational output has settled.
// ----------------------------------------------------------------------------
module tb_data_memory;
   import data_memory_pkg::*;

   localparam logic [2:0] SZ_B = 3'b001;
   localparam logic [2:0] SZ_H = 3'b010;
   localparam logic [2:0] SZ_W = 3'b100;
   localparam logic [2:0] SZ_0 = 3'b000;

   logic        clk = 1'b0;
   logic        rst;
   logic        MemWrite;
   logic        MemRead;
   logic        one_byte;
   logic        two_byte;
   logic        four_bytes;
   logic        unsigned_load;
   logic [11:0] Address;
   logic [31:0] WriteData;
   logic [31:0] ReadData;

   int checks = 0;
   int errors = 0;

   logic [31:0] expQ [$];
   string       tagQ [$];

   data_memory dut (
      .clk           (clk),
      .rst           (rst),
      .MemWrite      (MemWrite),
      .MemRead       (MemRead),
      .one_byte      (one_byte),
      .two_byte      (two_byte),
      .four_bytes    (four_bytes),
      .unsigned_load (unsigned_load),
      .Address       (Address),
      .WriteData     (WriteData),
      .ReadData      (ReadData)
   );

   // Free-running clock, 10 time units per period.
   always #5 clk = ~clk;

   task automatic setSize(input logic [2:0] sz);
      {four_bytes, two_byte, one_byte} = sz;
   endtask

   task automatic expectValue(input string tag, input logic [31:0] exp);
      expQ.push_back(exp);
      tagQ.push_back(tag);
   endtask

   task automatic checkOutput();
      logic [31:0] exp;
      string       tag;
      checks++;
      if (expQ.size() == 0) begin
         errors++;
         $error("[TB] FAIL scoreboard_empty observed=%h expected=<queued value>", ReadData);
      end else begin
         exp = expQ.pop_front();
         tag = tagQ.pop_front();
         assert (ReadData === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, ReadData, exp);
         end
      end
   endtask

   // Drive one load away from the clock edge, queue its expectation and
   // compare after the combinational path has settled.
   task automatic applyStimulus(input string tag, input int addr, input logic [2:0] sz,
                                input logic uns, input logic [31:0] exp);
      @(negedge clk);
      MemWrite      = 1'b0;
      MemRead       = 1'b1;
      Address       = 12'(addr);
      unsigned_load = uns;
      setSize(sz);
      expectValue(tag, exp);
      #2;
      checkOutput();
   endtask

   task automatic doStore(input int addr, input logic [2:0] sz, input logic [31:0] data);
      @(negedge clk);
      MemRead   = 1'b0;
      MemWrite  = 1'b1;
      Address   = 12'(addr);
      WriteData = data;
      setSize(sz);
      @(posedge clk);
      #1;
      MemWrite  = 1'b0;
   endtask

   initial begin
      rst           = 1'b0;
      MemWrite      = 1'b0;
      MemRead       = 1'b1;
      unsigned_load = 1'b0;
      Address       = '0;
      WriteData     = '0;
      setSize(SZ_W);

      #2;
      expectValue("reset_state", 32'h0000_0000);
      checkOutput();
      #10;
      rst = 1'b1;

      // Word store and load, unsigned flag ignored for words.
      doStore(0, SZ_W, 32'hDEAD_BEEF);
      applyStimulus("word_load",        0, SZ_W, 1'b0, 32'hDEAD_BEEF);
      applyStimulus("word_load_uns",    0, SZ_W, 1'b1, 32'hDEAD_BEEF);
      applyStimulus("half_signed_beef", 0, SZ_H, 1'b0, 32'hFFFF_BEEF);
      applyStimulus("byte_signed_de",   3, SZ_B, 1'b0, 32'hFFFF_FFDE);
      applyStimulus("no_size_flag",     0, SZ_0, 1'b0, 32'h0000_0000);

      // MemRead low forces zero even with a valid address and size.
      @(negedge clk);
      MemRead = 1'b0;
      Address = 12'd0;
      setSize(SZ_W);
      expectValue("memread_low", 32'h0000_0000);
      #2;
      checkOutput();

      // Byte and halfword extension.
      doStore(4, SZ_B, 32'h0000_00FF);
      applyStimulus("byte_signed",   4, SZ_B, 1'b0, 32'hFFFF_FFFF);
      applyStimulus("byte_unsigned", 4, SZ_B, 1'b1, 32'h0000_00FF);
      doStore(8, SZ_H, 32'h0000_FFFF);
      applyStimulus("half_signed",   8, SZ_H, 1'b0, 32'hFFFF_FFFF);
      applyStimulus("half_unsigned", 8, SZ_H, 1'b1, 32'h0000_FFFF);

      // Little-endian byte order and size priority.
      doStore(12, SZ_W, 32'h1234_5678);
      applyStimulus("endian_b12",     12, SZ_B, 1'b1, 32'h0000_0078);
      applyStimulus("endian_b13",     13, SZ_B, 1'b1, 32'h0000_0056);
      applyStimulus("endian_h12",     12, SZ_H, 1'b1, 32'h0000_5678);
      applyStimulus("half_pos_h14",   14, SZ_H, 1'b0, 32'h0000_1234);
      applyStimulus("prio_half_word", 12, 3'b110, 1'b1, 32'h0000_5678);
      applyStimulus("prio_all_flags", 13, 3'b111, 1'b1, 32'h0000_0056);
      doStore(16, 3'b111, 32'h9988_7766);
      applyStimulus("prio_store_byte", 16, SZ_W, 1'b0, 32'h0000_0066);

      // Unaligned word.
      doStore(21, SZ_W, 32'hA1B2_C3D4);
      applyStimulus("unaligned_word", 21, SZ_W, 1'b0, 32'hA1B2_C3D4);
      applyStimulus("unaligned_b22",  22, SZ_B, 1'b0, 32'hFFFF_FFC3);
      applyStimulus("unaligned_h23",  23, SZ_H, 1'b1, 32'h0000_A1B2);

      // Top-of-memory boundary: no wrap on stores or loads.
      doStore(MEM_BYTES - 4, SZ_W, 32'hAAAA_BBBB);
      applyStimulus("top_word",        4092, SZ_W, 1'b0, 32'hAAAA_BBBB);
      doStore(4095, SZ_B, 32'hCCCC_DDDD);
      applyStimulus("top_byte_uns",    4095, SZ_B, 1'b1, 32'h0000_00DD);
      applyStimulus("top_byte_sgn",    4095, SZ_B, 1'b0, 32'hFFFF_FFDD);
      applyStimulus("top_half_uns",    4095, SZ_H, 1'b1, 32'h0000_00DD);
      applyStimulus("top_half_sgn",    4095, SZ_H, 1'b0, 32'h0000_00DD);
      applyStimulus("top_word_merged", 4092, SZ_W, 1'b0, 32'hDDAA_BBBB);
      doStore(4094, SZ_W, 32'h1122_3344);
      applyStimulus("top_word_clip",   4092, SZ_W, 1'b0, 32'h3344_BBBB);
      applyStimulus("no_wrap_at_0",    0,    SZ_W, 1'b0, 32'hDEAD_BEEF);

      // Read and write together: old contents before the edge, new after.
      @(negedge clk);
      MemRead   = 1'b1;
      MemWrite  = 1'b1;
      Address   = 12'd32;
      WriteData = 32'h5566_7788;
      setSize(SZ_W);
      expectValue("rdw_pre_edge", 32'h0000_0000);
      #1;
      checkOutput();
      @(posedge clk);
      expectValue("rdw_post_edge", 32'h5566_7788);
      #1;
      MemWrite = 1'b0;
      checkOutput();

      // Asynchronous reset mid-cycle clears memory and gates the output.
      @(negedge clk);
      #1;
      rst     = 1'b0;
      MemRead = 1'b1;
      Address = 12'd12;
      setSize(SZ_W);
      expectValue("rst_hold", 32'h0000_0000);
      #1;
      checkOutput();
      @(posedge clk);
      #2;
      rst = 1'b1;
      applyStimulus("rst_cleared_4096", 4096, SZ_W, 1'b0, 32'h0000_0000);
      applyStimulus("rst_cleared_12",   12,   SZ_W, 1'b0, 32'h0000_0000);
      applyStimulus("rst_cleared_top",  4092, SZ_W, 1'b0, 32'h0000_0000);

      checks++;
      assert (expQ.size() == 0) else begin
         errors++;
         $error("[TB] FAIL scoreboard_leftover observed=%0d expected=0", expQ.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
